periph_bus_fabric: RTL and testbench

PERIPH_BUS_FABRIC -- requirements
Module: periph_bus_fabric

---
 rtl/bus_pkg.sv | 21 ++
 rtl/prio_enc.sv | 24 ++
 rtl/periph_bus_fabric.sv | 151 +++++++++++++++
 tb/tb_periph_bus_fabric.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus fabric: FSM encoding,
// default open-bus value and the captured access descriptor.
package bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] OPEN_BUS_DEF = 8'hFF;

  typedef struct packed {
    logic is_rd;
    logic is_io;
  } acc_t;

  // Index register width; a single-slave fabric still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index priority encoder with any-set and multi-set flags.
module prio_enc #(
  parameter int W     = 8,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any_set,
  output logic             multi_set
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any_set   = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_set = |(req & (req - W'(1)));

endmodule

// File: rtl/periph_bus_fabric.sv
// Peripheral read/write fabric: picks a target slave on a CPU strobe,
// stretches the cycle while the slave is not ready, aborts after a
// bounded wait and returns registered read data with a one-cycle valid.
//
// state   | meaning
// IDLE    | accepting a new strobe
// WAIT    | target not ready, oReady low, wait counter running
// DONE    | one-cycle completion, oRdValid/oTimeout pulses visible
module periph_bus_fabric
  import bus_pkg::*;
#(
  parameter int                NUM_SLAVES = 8,
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 20,
  parameter int                TIMEOUT    = 15,
  parameter logic [DATA_W-1:0] OPEN_BUS   = DATA_W'(OPEN_BUS_DEF)
) (
  input  logic                         iClk,
  input  logic                         iRstN,
  input  logic [ADDR_W-1:0]            iAddr,
  input  logic                         iMemRd,
  input  logic                         iMemWr,
  input  logic                         iIoRd,
  input  logic                         iIoWr,
  input  logic [NUM_SLAVES-1:0]        iSlvSel,
  input  logic [NUM_SLAVES*DATA_W-1:0] iSlvData,
  input  logic [NUM_SLAVES-1:0]        iSlvReady,
  input  logic [DATA_W-1:0]            iDefData,
  output logic [DATA_W-1:0]            oRdData,
  output logic                         oRdValid,
  output logic                         oReady,
  output logic                         oConflict,
  output logic                         oTimeout,
  output logic [7:0]                   oErrCnt
);

  localparam int         IDX_W = idx_width(NUM_SLAVES);
  localparam logic [7:0] TMO   = 8'(TIMEOUT);

  logic [1:0]       state_q;
  logic [7:0]       cnt_q;
  logic [IDX_W-1:0] tgt_q;
  acc_t             acc_q;
  acc_t             acc_d;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             sel_multi;
  logic [3:0]       stb;
  logic             any_stb;
  logic             multi_stb;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_rdy;
  logic [DATA_W-1:0] cur_data;

  // The address is decoded upstream into iSlvSel; kept on the port for tracing.
  logic unused_addr;
  assign unused_addr = ^iAddr;

  prio_enc #(.W(NUM_SLAVES), .IDX_W(IDX_W)) u_prio_enc (
    .req      (iSlvSel),
    .idx      (sel_idx),
    .any_set  (sel_any),
    .multi_set(sel_multi)
  );

  // Strobe decode with priority IoRd > MemRd > IoWr > MemWr.
  always_comb begin
    stb       = {iIoRd, iMemRd, iIoWr, iMemWr};
    any_stb   = |stb;
    multi_stb = |(stb & (stb - 4'd1));
    acc_d     = '{is_rd: 1'b0, is_io: 1'b0};
    if (iIoRd)       acc_d = '{is_rd: 1'b1, is_io: 1'b1};
    else if (iMemRd) acc_d = '{is_rd: 1'b1, is_io: 1'b0};
    else if (iIoWr)  acc_d = '{is_rd: 1'b0, is_io: 1'b1};
  end

  // Live target: fresh select in IDLE, latched target afterwards.
  always_comb begin
    cur_idx  = (state_q == ST_IDLE) ? sel_idx : tgt_q;
    cur_rdy  = iSlvReady[cur_idx];
    cur_data = iSlvData[cur_idx*DATA_W +: DATA_W];
  end

  assign oReady = (state_q != ST_WAIT);

  // Transaction FSM, wait counter, registered read data and status pulses.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      tgt_q     <= '0;
      acc_q     <= '{is_rd: 1'b0, is_io: 1'b0};
      oRdData   <= '0;
      oRdValid  <= 1'b0;
      oConflict <= 1'b0;
      oTimeout  <= 1'b0;
      oErrCnt   <= 8'd0;
    end else begin
      oRdValid  <= 1'b0;
      oConflict <= 1'b0;
      oTimeout  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_stb) begin
            acc_q     <= acc_d;
            tgt_q     <= sel_idx;
            cnt_q     <= 8'd0;
            oConflict <= sel_multi | multi_stb;
            if (!sel_any) begin
              // Unclaimed: memory falls to default SRAM, I/O reads float.
              state_q <= ST_DONE;
              if (acc_d.is_rd) begin
                oRdValid <= 1'b1;
                oRdData  <= acc_d.is_io ? OPEN_BUS : iDefData;
              end
            end else if (cur_rdy) begin
              state_q <= ST_DONE;
              if (acc_d.is_rd) begin
                oRdValid <= 1'b1;
                oRdData  <= cur_data;
              end
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (cur_rdy) begin
            state_q <= ST_DONE;
            if (acc_q.is_rd) begin
              oRdValid <= 1'b1;
              oRdData  <= cur_data;
            end
          end else if (cnt_q + 8'd1 == TMO) begin
            state_q  <= ST_DONE;
            oTimeout <= 1'b1;
            if (oErrCnt != 8'hFF) oErrCnt <= oErrCnt + 8'd1;
            if (acc_q.is_rd) begin
              oRdValid <= 1'b1;
              oRdData  <= OPEN_BUS;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_fabric.sv
// Directed bench for periph_bus_fabric: one task per scenario.
module tb_periph_bus_fabric;

  logic        iClk;
  logic        iRstN;
  logic [19:0] iAddr;
  logic        iMemRd, iMemWr, iIoRd, iIoWr;
  logic [7:0]  iSlvSel;
  logic [63:0] iSlvData;
  logic [7:0]  iSlvReady;
  logic [7:0]  iDefData;
  logic [7:0]  oRdData;
  logic        oRdValid, oReady, oConflict, oTimeout;
  logic [7:0]  oErrCnt;

  int checks = 0;
  int errors = 0;

  periph_bus_fabric dut (
    .iClk(iClk), .iRstN(iRstN), .iAddr(iAddr),
    .iMemRd(iMemRd), .iMemWr(iMemWr), .iIoRd(iIoRd), .iIoWr(iIoWr),
    .iSlvSel(iSlvSel), .iSlvData(iSlvData), .iSlvReady(iSlvReady),
    .iDefData(iDefData), .oRdData(oRdData), .oRdValid(oRdValid),
    .oReady(oReady), .oConflict(oConflict), .oTimeout(oTimeout),
    .oErrCnt(oErrCnt)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic clr_stb();
    iMemRd = 0; iMemWr = 0; iIoRd = 0; iIoWr = 0;
  endtask

  task automatic test_reset();
    iRstN = 0; iAddr = 20'h0; clr_stb();
    iSlvSel = 8'h00; iSlvData = 64'h0; iSlvReady = 8'hFF; iDefData = 8'h00;
    #12;
    checks++; if (oRdData !== 8'h00) begin errors++; $display("FAIL reset_rddata got %h want 00", oRdData); end
    checks++; if (oRdValid !== 1'b0 || oConflict !== 1'b0 || oTimeout !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b%b want 000", oRdValid, oConflict, oTimeout); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", oReady); end
    checks++; if (oErrCnt !== 8'h00) begin errors++; $display("FAIL reset_errcnt got %h want 00", oErrCnt); end
    @(negedge iClk); iRstN = 1;
    tick();
  endtask

  task automatic test_io_read_sel();
    iSlvSel = 8'b0000_0100; iSlvData = 64'h0; iSlvData[2*8 +: 8] = 8'h5A; iSlvReady = 8'hFF;
    iIoRd = 1; iAddr = 20'h00040;
    tick(); clr_stb(); iSlvSel = 8'h00;
    checks++; if (oRdValid !== 1'b1 || oRdData !== 8'h5A) begin errors++; $display("FAIL io_read valid/data got %b/%h want 1/5a", oRdValid, oRdData); end
    checks++; if (oReady !== 1'b1 || oConflict !== 1'b0) begin errors++; $display("FAIL io_read ready/conflict got %b/%b want 1/0", oReady, oConflict); end
    tick();
    checks++; if (oRdValid !== 1'b0) begin errors++; $display("FAIL io_read_pulse got %b want 0", oRdValid); end
  endtask

  task automatic test_unclaimed();
    iSlvSel = 8'h00; iIoRd = 1;
    tick(); clr_stb();
    checks++; if (oRdValid !== 1'b1 || oRdData !== 8'hFF) begin errors++; $display("FAIL open_bus got %b/%h want 1/ff", oRdValid, oRdData); end
    tick();
    iDefData = 8'h3C; iMemRd = 1;
    tick(); clr_stb();
    checks++; if (oRdValid !== 1'b1 || oRdData !== 8'h3C) begin errors++; $display("FAIL def_mem got %b/%h want 1/3c", oRdValid, oRdData); end
    tick();
    iMemWr = 1;
    tick(); clr_stb();
    checks++; if (oRdValid !== 1'b0 || oReady !== 1'b1 || oRdData !== 8'h3C) begin errors++; $display("FAIL def_write got %b/%b/%h want 0/1/3c", oRdValid, oReady, oRdData); end
    tick();
  endtask

  task automatic test_conflict();
    iSlvData = 64'h0; iSlvData[1*8 +: 8] = 8'h11; iSlvData[4*8 +: 8] = 8'h44;
    iSlvSel = 8'b0001_0010; iMemRd = 1;
    tick(); clr_stb(); iSlvSel = 8'h00;
    checks++; if (oConflict !== 1'b1 || oRdData !== 8'h11) begin errors++; $display("FAIL sel_conflict got %b/%h want 1/11", oConflict, oRdData); end
    tick();
    checks++; if (oConflict !== 1'b0) begin errors++; $display("FAIL conflict_pulse got %b want 0", oConflict); end
    iSlvData[0 +: 8] = 8'h99; iSlvSel = 8'b0000_0001; iIoRd = 1; iMemWr = 1;
    tick(); clr_stb(); iSlvSel = 8'h00;
    checks++; if (oConflict !== 1'b1 || oRdValid !== 1'b1 || oRdData !== 8'h99) begin errors++; $display("FAIL stb_conflict got %b/%b/%h want 1/1/99", oConflict, oRdValid, oRdData); end
    tick();
  endtask

  task automatic test_wait();
    int low;
    low = 0;
    iSlvData = 64'h0; iSlvSel = 8'b0000_1000; iSlvReady = 8'hF7; iMemRd = 1;
    tick(); clr_stb(); iSlvSel = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin iIoRd = 1; iSlvSel = 8'h01; end
      if (i == 3) begin iSlvReady = 8'hFF; iSlvData[3*8 +: 8] = 8'hA5; end
      if (oReady === 1'b0) low++;
      tick(); clr_stb(); iSlvSel = 8'h00;
    end
    checks++; if (low != 4) begin errors++; $display("FAIL wait_ready_low got %0d want 4", low); end
    checks++; if (oRdValid !== 1'b1 || oRdData !== 8'hA5 || oReady !== 1'b1) begin errors++; $display("FAIL wait_done got %b/%h/%b want 1/a5/1", oRdValid, oRdData, oReady); end
    tick();
    checks++; if (oRdValid !== 1'b0 || oReady !== 1'b1) begin errors++; $display("FAIL wait_ignored_stb got %b/%b want 0/1", oRdValid, oReady); end
  endtask

  task automatic test_timeout();
    int n;
    int exp_cnt;
    exp_cnt = 0;
    iSlvReady = 8'hF7;
    for (int k = 0; k < 300; k++) begin
      n = 0;
      iSlvSel = 8'b0000_1000; iIoRd = 1;
      tick(); clr_stb(); iSlvSel = 8'h00;
      while (oReady === 1'b0 && n < 40) begin n++; tick(); end
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (k == 0) begin
        checks++; if (n != 15) begin errors++; $display("FAIL timeout_wait got %0d want 15", n); end
        checks++; if (oTimeout !== 1'b1 || oRdData !== 8'hFF || oErrCnt !== 8'd1) begin errors++; $display("FAIL timeout_done got %b/%h/%0d want 1/ff/1", oTimeout, oRdData, oErrCnt); end
      end
      if (k == 199) begin
        checks++; if (oErrCnt !== 8'(exp_cnt)) begin errors++; $display("FAIL errcnt_200 got %0d want %0d", oErrCnt, exp_cnt); end
      end
      if (n >= 40) begin
        checks++; errors++; $display("FAIL timeout_bound got %0d want 15", n);
        break;
      end
      tick();
      if (k == 0) begin
        checks++; if (oTimeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", oTimeout); end
      end
    end
    checks++; if (oErrCnt !== 8'd255) begin errors++; $display("FAIL errcnt_sat got %0d want 255", oErrCnt); end
  endtask

  task automatic test_reset_mid_wait();
    iSlvReady = 8'hF7; iSlvSel = 8'b0000_1000; iMemRd = 1;
    tick(); clr_stb(); iSlvSel = 8'h00;
    tick();
    checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL pre_reset_wait got %b want 0", oReady); end
    #2 iRstN = 0;
    #1;
    checks++; if (oReady !== 1'b1 || oErrCnt !== 8'h00 || oRdData !== 8'h00) begin errors++; $display("FAIL mid_reset got %b/%h/%h want 1/00/00", oReady, oErrCnt, oRdData); end
    checks++; if (oRdValid !== 1'b0 || oTimeout !== 1'b0 || oConflict !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses got %b%b%b want 000", oRdValid, oTimeout, oConflict); end
    @(negedge iClk); iRstN = 1;
    iSlvReady = 8'hFF; iSlvData[3*8 +: 8] = 8'h77; iSlvSel = 8'b0000_1000; iMemRd = 1;
    tick(); clr_stb(); iSlvSel = 8'h00;
    checks++; if (oRdValid !== 1'b1 || oRdData !== 8'h77) begin errors++; $display("FAIL post_reset got %b/%h want 1/77", oRdValid, oRdData); end
    tick();
  endtask

  task automatic test_back_to_back();
    iSlvData = 64'h0; iSlvData[5*8 +: 8] = 8'hC3; iSlvData[6*8 +: 8] = 8'h6E; iSlvReady = 8'hFF;
    iSlvSel = 8'b0010_0000; iIoRd = 1;
    tick();
    iSlvSel = 8'b0100_0000;
    checks++; if (oRdData !== 8'hC3) begin errors++; $display("FAIL b2b_first got %h want c3", oRdData); end
    tick(); clr_stb(); iSlvSel = 8'h00;
    checks++; if (oRdValid !== 1'b0) begin errors++; $display("FAIL b2b_done_ignore got %b want 0", oRdValid); end
    iSlvSel = 8'b0100_0000; iIoWr = 1;
    tick(); clr_stb(); iSlvSel = 8'h00;
    checks++; if (oRdValid !== 1'b0 || oRdData !== 8'hC3) begin errors++; $display("FAIL b2b_write got %b/%h want 0/c3", oRdValid, oRdData); end
    tick();
    iSlvSel = 8'b0100_0000; iMemRd = 1;
    tick(); clr_stb(); iSlvSel = 8'h00;
    checks++; if (oRdValid !== 1'b1 || oRdData !== 8'h6E) begin errors++; $display("FAIL b2b_second got %b/%h want 1/6e", oRdValid, oRdData); end
    tick();
  endtask

  initial begin
    test_reset();
    test_io_read_sel();
    test_unclaimed();
    test_conflict();
    test_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
